// File: rtl/arm_shift_sequencer.sv
// -----------------------------------------------------------------------------
// arm_shift_sequencer
//
// Iterative ARM operand-2 shifter for register-specified shifts (LSL, LSR,
// ASR, ROR by Rs[7:0]). One single-bit step is performed per cycle, so a
// shift by n costs n+1 cycles from accept to the done pulse. The bit-serial
// stepping reproduces the ARM boundary semantics for amounts of 32 and above
// without any special-case datapath.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   request pulse, accepted only in IDLE or DONE
//   abort      in   1   synchronous cancel of an in-flight shift
//   shift_type in   2   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   amount     in   8   shift amount (Rs[7:0])
//   operand    in  32   value to shift (Rm)
//   carry_in   in   1   current CPSR C flag
//   busy       out  1   high while shifting
//   done       out  1   one-cycle pulse, result/carry_out valid
//   result     out 32   shifted operand, held until the next completion
//   carry_out  out  1   shifter carry-out, held with result
// -----------------------------------------------------------------------------
module arm_shift_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  shift_type,
  input  logic [7:0]  amount,
  input  logic [31:0] operand,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  localparam logic [1:0] TYPE_LSL = 2'b00;
  localparam logic [1:0] TYPE_LSR = 2'b01;
  localparam logic [1:0] TYPE_ASR = 2'b10;
  localparam logic [1:0] TYPE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of single-bit steps needed. Amounts past 33 (LSL/LSR) or 32 (ASR)
  // give the same answer as the clamp value, so the counter stays 6 bits wide.
  // ROR only cares about amount mod 32, with a full 32-step turn standing in
  // for nonzero multiples of 32 so the carry picks up operand[31].
  function automatic logic [5:0] iter_count(input logic [1:0] t,
                                            input logic [7:0] amt);
    logic [5:0] n;
    n = 6'd0;
    if (amt == 8'd0) begin
      n = 6'd0;
    end else begin
      case (t)
        TYPE_LSL, TYPE_LSR: n = (amt >= 8'd33) ? 6'd33 : amt[5:0];
        TYPE_ASR:           n = (amt >= 8'd32) ? 6'd32 : amt[5:0];
        TYPE_ROR:           n = (amt[4:0] == 5'd0) ? 6'd32 : {1'b0, amt[4:0]};
        default:            n = 6'd0;
      endcase
    end
    return n;
  endfunction

  // One single-bit shift step; returns {new_carry, new_word}.
  function automatic logic [32:0] shift_step(input logic [1:0]  t,
                                             input logic [31:0] w,
                                             input logic        c);
    logic [32:0] r;
    r = {c, w};
    case (t)
      TYPE_LSL: r = {w[31], w[30:0], 1'b0};
      TYPE_LSR: r = {w[0], 1'b0, w[31:1]};
      TYPE_ASR: r = {w[0], w[31], w[31:1]};
      TYPE_ROR: r = {w[0], w[0], w[31:1]};
      default:  r = {c, w};
    endcase
    return r;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [5:0]  cnt_r;
  logic [31:0] work_r;
  logic        wcarry_r;
  logic [1:0]  type_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] result_r;
  logic        carry_out_r;

  logic        accept_s;
  logic [5:0]  count_s;
  logic [32:0] step_s;
  logic        busy_nxt_s;
  logic        done_nxt_s;
  logic [31:0] result_nxt_s;
  logic        carry_nxt_s;

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign count_s  = iter_count(shift_type, amount);
  assign step_s   = shift_step(type_r, work_r, wcarry_r);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort outranks the final step completing
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = (count_s == 6'd0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 6'd1) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decided from the
  // upcoming state so the flops line up with the state they describe
  always_comb begin
    busy_nxt_s   = (state_nxt_s == ST_SHIFT);
    done_nxt_s   = (state_nxt_s == ST_DONE);
    result_nxt_s = result_r;
    carry_nxt_s  = carry_out_r;
    if (done_nxt_s) begin
      if (accept_s) begin
        // zero-step request: operand and carry pass straight through
        result_nxt_s = operand;
        carry_nxt_s  = carry_in;
      end else begin
        result_nxt_s = step_s[31:0];
        carry_nxt_s  = step_s[32];
      end
    end else begin
      result_nxt_s = result_r;
      carry_nxt_s  = carry_out_r;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= 32'd0;
      carry_out_r <= 1'b0;
    end else begin
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      result_r    <= result_nxt_s;
      carry_out_r <= carry_nxt_s;
    end
  end

  // Working datapath: load on accept, step once per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 6'd0;
      work_r   <= 32'd0;
      wcarry_r <= 1'b0;
      type_r   <= 2'b00;
    end else if (accept_s) begin
      cnt_r    <= count_s;
      work_r   <= operand;
      wcarry_r <= carry_in;
      type_r   <= shift_type;
    end else if ((state_r == ST_SHIFT) && !abort) begin
      cnt_r    <= cnt_r - 6'd1;
      work_r   <= step_s[31:0];
      wcarry_r <= step_s[32];
    end else begin
      cnt_r    <= cnt_r;
      work_r   <= work_r;
      wcarry_r <= wcarry_r;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign carry_out = carry_out_r;

endmodule

// File: tb/tb_arm_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_arm_shift_sequencer
//
// Bench for arm_shift_sequencer. A reference model computes each operation's
// final value, carry and step count directly from ARM shift arithmetic and
// tracks when done must pulse; a compare process checks all outputs against
// it on every falling edge. Directed cases pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_arm_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  shift_type = 2'b00;
  logic [7:0]  amount = 8'd0;
  logic [31:0] operand = 32'd0;
  logic        carry_in = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  arm_shift_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .shift_type (shift_type),
    .amount     (amount),
    .operand    (operand),
    .carry_in   (carry_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (ARM shift arithmetic) ----------------
  function automatic logic [31:0] ref_result(input logic [1:0] t, input int a,
                                             input logic [31:0] op);
    int r;
    r = a % 32;
    if (a == 0) return op;
    case (t)
      2'b00: return (a < 32) ? (op << a) : 32'd0;
      2'b01: return (a < 32) ? (op >> a) : 32'd0;
      2'b10: return (a < 32) ? 32'($signed(op) >>> a) : {32{op[31]}};
      default: return (r == 0) ? op : ((op >> r) | (op << (32 - r)));
    endcase
  endfunction

  function automatic logic ref_carry(input logic [1:0] t, input int a,
                                     input logic [31:0] op, input logic cin);
    int r;
    r = a % 32;
    if (a == 0) return cin;
    case (t)
      2'b00: return (a <= 32) ? op[32 - a] : 1'b0;
      2'b01: return (a <= 32) ? op[a - 1] : 1'b0;
      2'b10: return (a < 32) ? op[a - 1] : op[31];
      default: return (r == 0) ? op[31] : op[r - 1];
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] t, input int a);
    if (a == 0) return 0;
    case (t)
      2'b00, 2'b01: return (a > 33) ? 33 : a;
      2'b10: return (a > 32) ? 32 : a;
      default: return ((a % 32) == 0) ? 32 : (a % 32);
    endcase
  endfunction

  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_result = 32'd0;
  logic        exp_carry = 1'b0;
  logic        m_active = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_res = 32'd0;
  logic        m_c = 1'b0;

  // Model: remembers the pending answer and how many cycles remain
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_busy   <= 1'b0;
      exp_done   <= 1'b0;
      exp_result <= 32'd0;
      exp_carry  <= 1'b0;
      m_active   <= 1'b0;
      m_rem      <= 0;
    end else begin
      exp_done <= 1'b0;
      if (m_active) begin
        if (abort) begin
          m_active <= 1'b0;
          exp_busy <= 1'b0;
        end else if (m_rem == 1) begin
          m_active   <= 1'b0;
          exp_busy   <= 1'b0;
          exp_done   <= 1'b1;
          exp_result <= m_res;
          exp_carry  <= m_c;
        end else begin
          m_rem <= m_rem - 1;
        end
      end else if (start) begin
        if (ref_latency(shift_type, int'(amount)) == 0) begin
          exp_done   <= 1'b1;
          exp_result <= operand;
          exp_carry  <= carry_in;
        end else begin
          m_active <= 1'b1;
          exp_busy <= 1'b1;
          m_rem    <= ref_latency(shift_type, int'(amount));
          m_res    <= ref_result(shift_type, int'(amount), operand);
          m_c      <= ref_carry(shift_type, int'(amount), operand, carry_in);
        end
      end
    end
  end

  // Compare process: all outputs against the model every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check1("cmp busy", busy, exp_busy);
      check1("cmp done", done, exp_done);
      check32("cmp result", result, exp_result);
      check1("cmp carry_out", carry_out, exp_carry);
    end
  end

  // Waits (bounded) for done after a start has been driven; checks busy per cycle
  task automatic wait_done(input int elat, input string nm, output logic got,
                           output logic [31:0] r, output logic c, output int k);
    k = 0; got = 1'b0; r = 32'd0; c = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      check1({nm, " busy"}, busy, logic'(k < elat));
      if (done) begin
        got = 1'b1; r = result; c = carry_out;
      end
      #1 start = 1'b0;
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic [7:0] a,
                       input logic [31:0] op, input logic cin);
    shift_type = t; amount = a; operand = op; carry_in = cin; start = 1'b1;
  endtask

  task automatic do_op(input string nm, input logic [1:0] t, input logic [7:0] a,
                       input logic [31:0] op, input logic cin,
                       input logic [31:0] er, input logic ec, input int elat);
    logic got; logic [31:0] r; logic c; int k;
    @(negedge clk); #1;
    drive(t, a, op, cin);
    wait_done(elat, nm, got, r, c, k);
    check1({nm, " done seen"}, got, 1'b1);
    check_int({nm, " latency"}, k, elat);
    check32({nm, " result"}, r, er);
    check1({nm, " carry"}, c, ec);
  endtask

  initial begin
    logic got; logic [31:0] r; logic c; int k; int ndone; int kdone;
    int amt_pick;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check32("reset result", result, 32'd0);
    check1("reset carry", carry_out, 1'b0);
    #19 rst_n = 1'b1;

    do_op("lsl1", 2'b00, 8'd1, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1, 2);
    do_op("asr40", 2'b10, 8'd40, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 33);
    do_op("ror32", 2'b11, 8'd32, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1, 33);
    do_op("ror8", 2'b11, 8'd8, 32'h0000_00A5, 1'b0, 32'hA500_0000, 1'b1, 9);
    do_op("lsr32", 2'b01, 8'd32, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 33);
    do_op("lsr33", 2'b01, 8'd33, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34);
    do_op("amt0", 2'b01, 8'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1);
    do_op("lsl32", 2'b00, 8'd32, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 33);
    do_op("lsl200", 2'b00, 8'd200, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 34);

    // back-to-back: second start held in the DONE cycle
    @(negedge clk); #1;
    drive(2'b01, 8'd3, 32'h0000_00F0, 1'b1);
    wait_done(4, "b2b first", got, r, c, k);
    check32("b2b first result", r, 32'h0000_001E);
    check1("b2b first carry", c, 1'b0);
    drive(2'b11, 8'd4, 32'h0000_000F, 1'b0);
    wait_done(5, "b2b second", got, r, c, k);
    check_int("b2b second latency", k, 5);
    check32("b2b second result", r, 32'hF000_0000);
    check1("b2b second carry", c, 1'b1);

    // start mid-shift ignored: one done only, at the original latency
    @(negedge clk); #1;
    drive(2'b00, 8'd20, 32'h0000_0001, 1'b0);
    ndone = 0; kdone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin ndone++; if (kdone == 0) kdone = i; end
      #1;
      if (i == 5) drive(2'b01, 8'd2, 32'hDEAD_BEEF, 1'b1);
      else start = 1'b0;
    end
    check_int("midstart done count", ndone, 1);
    check_int("midstart done cycle", kdone, 21);
    check32("midstart result", result, 32'h0010_0000);

    // abort mid LSL 20: no done, result unchanged
    @(negedge clk); #1;
    drive(2'b00, 8'd20, 32'h0000_1234, 1'b1);
    ndone = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
      #1 start = 1'b0;
      abort = (i == 5);
    end
    check_int("abort done count", ndone, 0);
    check32("abort result held", result, 32'h0010_0000);
    check1("abort busy low", busy, 1'b0);

    // asynchronous reset in cycle 5 of a 20-cycle shift
    @(negedge clk); #1;
    drive(2'b00, 8'd20, 32'h0000_0003, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1 start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    check1("async rst busy", busy, 1'b0);
    check1("async rst done", done, 1'b0);
    check32("async rst result", result, 32'd0);
    check1("async rst carry", carry_out, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    do_op("after rst", 2'b10, 8'd4, 32'h8000_0010, 1'b0, 32'hF800_0001, 1'b0, 5);

    // randomized traffic, compare process does the checking
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      shift_type = 2'($urandom_range(0, 3));
      amt_pick = $urandom_range(0, 9);
      case (amt_pick)
        0: amount = 8'd0;
        1: amount = 8'd1;
        2: amount = 8'd31;
        3: amount = 8'd32;
        4: amount = 8'd33;
        5: amount = 8'd64;
        default: amount = 8'($urandom_range(0, 255));
      endcase
      operand = $urandom;
      carry_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
